// File: rtl/cpu_pkg.sv
// Shared constants for the single-cycle 8-bit CPU: widths, opcodes,
// instruction field positions and the branch-target helper.
package cpu_pkg;

    localparam int PC_W   = 32;
    localparam int DATA_W = 8;
    localparam int NREG   = 8;
    localparam int REG_AW = 3;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_BNE   = 8'h08;
    localparam logic [7:0] OP_MULT  = 8'h09;
    localparam logic [7:0] OP_SLL   = 8'h0A;
    localparam logic [7:0] OP_SRL   = 8'h0B;
    localparam logic [7:0] OP_SRA   = 8'h0C;
    localparam logic [7:0] OP_ROR   = 8'h0D;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 24;
    localparam int OFF_MSB  = 23;
    localparam int OFF_LSB  = 16;
    localparam int DEST_MSB = 18;
    localparam int DEST_LSB = 16;
    localparam int SRC1_MSB = 10;
    localparam int SRC1_LSB = 8;
    localparam int SRC2_MSB = 2;
    localparam int SRC2_LSB = 0;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;

    // Offset counts words relative to the following instruction.
    function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0] pc,
                                                      input logic [7:0]      off);
        return pc + 32'd4 + {{22{off[7]}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/cpu_reg_file.sv
// 8x8 register file: two combinational read ports, one write port on the
// rising edge, asynchronously cleared.
module reg_file
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] reg_array [0:NREG-1];

    // Storage: cleared by reset, otherwise written when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                reg_array[i] <= {DATA_W{1'b0}};
            end
        end else if (we) begin
            reg_array[waddr] <= wdata;
        end
    end

    assign rdata1 = reg_array[raddr1];
    assign rdata2 = reg_array[raddr2];

endmodule

// File: rtl/cpu.sv
// Single-cycle 8-bit processor: decode, register read, ALU and PC update
// all complete within one clock; state commits on the rising edge.
module cpu
    import cpu_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET,
    input  logic [31:0]     INSTRUCTION,
    output logic [PC_W-1:0] PC_OUT
);

    logic [PC_W-1:0]   pc_r;
    logic [PC_W-1:0]   next_pc_s;
    logic [7:0]        op_s;
    logic [7:0]        off_s;
    logic [7:0]        imm_s;
    logic [REG_AW-1:0] dest_s;
    logic [REG_AW-1:0] src1_s;
    logic [REG_AW-1:0] src2_s;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;
    logic [DATA_W-1:0] alu_res_s;
    logic [DATA_W-1:0] sra_s;
    logic [15:0]       prod_s;
    logic [15:0]       rot_s;
    logic              big_shift_s;
    logic              we_s;
    logic              taken_s;

    assign op_s   = INSTRUCTION[OP_MSB:OP_LSB];
    assign off_s  = INSTRUCTION[OFF_MSB:OFF_LSB];
    assign dest_s = INSTRUCTION[DEST_MSB:DEST_LSB];
    assign src1_s = INSTRUCTION[SRC1_MSB:SRC1_LSB];
    assign src2_s = INSTRUCTION[SRC2_MSB:SRC2_LSB];
    assign imm_s  = INSTRUCTION[IMM_MSB:IMM_LSB];

    reg_file u_regfile (
        .clk    (CLK),
        .rst_n  (RESET),
        .we     (we_s),
        .waddr  (dest_s),
        .wdata  (alu_res_s),
        .raddr1 (src1_s),
        .raddr2 (src2_s),
        .rdata1 (rd1_s),
        .rdata2 (rd2_s)
    );

    // Shift amounts of 8 or more saturate: sra clamps to 7 so only sign bits remain.
    assign big_shift_s = (imm_s[7:3] != 5'd0);
    assign prod_s      = {8'd0, rd1_s} * {8'd0, rd2_s};
    assign rot_s       = {rd1_s, rd1_s} >> imm_s[2:0];
    assign sra_s       = $signed(rd1_s) >>> (big_shift_s ? 3'd7 : imm_s[2:0]);

    // Opcode decode, ALU result and branch decision.
    always_comb begin
        alu_res_s = {DATA_W{1'b0}};
        we_s      = 1'b0;
        taken_s   = 1'b0;
        case (op_s)
            OP_LOADI: begin alu_res_s = imm_s;           we_s = 1'b1; end
            OP_MOV:   begin alu_res_s = rd2_s;           we_s = 1'b1; end
            OP_ADD:   begin alu_res_s = rd1_s + rd2_s;   we_s = 1'b1; end
            OP_SUB:   begin alu_res_s = rd1_s - rd2_s;   we_s = 1'b1; end
            OP_AND:   begin alu_res_s = rd1_s & rd2_s;   we_s = 1'b1; end
            OP_OR:    begin alu_res_s = rd1_s | rd2_s;   we_s = 1'b1; end
            OP_MULT:  begin alu_res_s = prod_s[7:0];     we_s = 1'b1; end
            OP_SLL:   begin
                alu_res_s = big_shift_s ? {DATA_W{1'b0}} : (rd1_s << imm_s[2:0]);
                we_s      = 1'b1;
            end
            OP_SRL:   begin
                alu_res_s = big_shift_s ? {DATA_W{1'b0}} : (rd1_s >> imm_s[2:0]);
                we_s      = 1'b1;
            end
            OP_SRA:   begin alu_res_s = sra_s;           we_s = 1'b1; end
            OP_ROR:   begin alu_res_s = rot_s[7:0];      we_s = 1'b1; end
            OP_J:     taken_s = 1'b1;
            OP_BEQ:   taken_s = (rd1_s == rd2_s);
            OP_BNE:   taken_s = (rd1_s != rd2_s);
            default:  taken_s = 1'b0;
        endcase
    end

    assign next_pc_s = taken_s ? branch_target(pc_r, off_s) : (pc_r + 32'd4);

    // Program counter register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc_r <= {PC_W{1'b0}};
        end else begin
            pc_r <= next_pc_s;
        end
    end

    assign PC_OUT = pc_r;

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed vector table, hand-written control
// flow and reset sequences, and random instructions against a reference model.
module tb_cpu;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] INSTRUCTION = 32'hFF00_0000;
    logic [31:0] PC_OUT;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_pc;
    logic [7:0]  m_reg [0:7];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] exp_pc;
        int          reg_idx;
        logic [7:0]  exp_val;
    } vec_t;

    vec_t vecs [0:21];

    cpu dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .INSTRUCTION (INSTRUCTION),
        .PC_OUT      (PC_OUT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] enc(input logic [7:0] op, input logic [7:0] dbyte,
                                        input logic [2:0] s1, input logic [7:0] low);
        return {op, dbyte, 5'd0, s1, low};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0;
        for (int i = 0; i < 8; i++) m_reg[i] = 8'd0;
    endtask

    // Reference semantics written directly from the instruction rules with integers.
    task automatic model_step(input logic [31:0] ins);
        int op, d, s1, s2, imm, off, a, b, res, sa, k;
        bit wr, br;
        op  = int'(ins[31:24]); d = int'(ins[18:16]); s1 = int'(ins[10:8]);
        s2  = int'(ins[2:0]);   imm = int'(ins[7:0]); off = int'(ins[23:16]);
        a   = int'(m_reg[s1]);  b = int'(m_reg[s2]);
        res = 0; wr = 1; br = 0;
        case (op)
            0:  res = imm;
            1:  res = b;
            2:  res = a + b;
            3:  res = a - b + 256;
            4:  res = a & b;
            5:  res = a | b;
            6:  begin wr = 0; br = 1; end
            7:  begin wr = 0; br = (a == b); end
            8:  begin wr = 0; br = (a != b); end
            9:  res = a * b;
            10: res = (imm >= 8) ? 0 : (a << imm);
            11: res = (imm >= 8) ? 0 : (a >> imm);
            12: begin
                sa  = (a >= 128) ? a - 256 : a;
                res = (imm >= 8) ? ((a >= 128) ? 255 : 0) : (sa >>> imm);
            end
            13: begin k = imm % 8; res = (a >> k) | (a << (8 - k)); end
            default: wr = 0;
        endcase
        if (wr) m_reg[d] = 8'(res & 255);
        if (br) m_pc = m_pc + 32'd4 + 32'(((off >= 128) ? off - 256 : off) * 4);
        else    m_pc = m_pc + 32'd4;
    endtask

    task automatic compare_state(input string tag);
        check({tag, "_pc"}, PC_OUT, m_pc);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_r%0d", tag, i), {24'd0, dut.u_regfile.reg_array[i]}, {24'd0, m_reg[i]});
        end
    endtask

    task automatic run(input logic [31:0] ins, input string tag);
        INSTRUCTION = ins;
        @(posedge CLK);
        #1;
        model_step(ins);
        compare_state(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset(input string tag);
        @(negedge CLK);
        #1 RESET = 1'b0;
        #1;
        model_reset();
        compare_state(tag);
        #1 RESET = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{enc(8'h00, 8'h01, 3'd0, 8'h05), 32'd4,  1, 8'h05};
        vecs[1]  = '{enc(8'h00, 8'h02, 3'd0, 8'h03), 32'd8,  2, 8'h03};
        vecs[2]  = '{enc(8'h02, 8'h03, 3'd1, 8'h02), 32'd12, 3, 8'h08};
        vecs[3]  = '{enc(8'h03, 8'h04, 3'd1, 8'h02), 32'd16, 4, 8'h02};
        vecs[4]  = '{enc(8'h03, 8'h04, 3'd2, 8'h01), 32'd20, 4, 8'hFE};
        vecs[5]  = '{enc(8'h00, 8'h01, 3'd0, 8'hF0), 32'd24, 1, 8'hF0};
        vecs[6]  = '{enc(8'h00, 8'h02, 3'd0, 8'h3C), 32'd28, 2, 8'h3C};
        vecs[7]  = '{enc(8'h04, 8'h03, 3'd1, 8'h02), 32'd32, 3, 8'h30};
        vecs[8]  = '{enc(8'h05, 8'h04, 3'd1, 8'h02), 32'd36, 4, 8'hFC};
        vecs[9]  = '{enc(8'h01, 8'h05, 3'd0, 8'h02), 32'd40, 5, 8'h3C};
        vecs[10] = '{enc(8'h00, 8'h01, 3'd0, 8'h10), 32'd44, 1, 8'h10};
        vecs[11] = '{enc(8'h00, 8'h02, 3'd0, 8'h11), 32'd48, 2, 8'h11};
        vecs[12] = '{enc(8'h09, 8'h06, 3'd1, 8'h02), 32'd52, 6, 8'h10};
        vecs[13] = '{enc(8'h00, 8'h01, 3'd0, 8'h81), 32'd56, 1, 8'h81};
        vecs[14] = '{enc(8'h0A, 8'h07, 3'd1, 8'h01), 32'd60, 7, 8'h02};
        vecs[15] = '{enc(8'h0B, 8'h07, 3'd1, 8'h01), 32'd64, 7, 8'h40};
        vecs[16] = '{enc(8'h0C, 8'h07, 3'd1, 8'h01), 32'd68, 7, 8'hC0};
        vecs[17] = '{enc(8'h0D, 8'h07, 3'd1, 8'h01), 32'd72, 7, 8'hC0};
        vecs[18] = '{enc(8'h0A, 8'h07, 3'd1, 8'h09), 32'd76, 7, 8'h00};
        vecs[19] = '{enc(8'h0C, 8'h07, 3'd1, 8'h09), 32'd80, 7, 8'hFF};
        vecs[20] = '{enc(8'h02, 8'h01, 3'd1, 8'h01), 32'd84, 1, 8'h02};
        vecs[21] = '{enc(8'h0E, 8'h01, 3'd1, 8'h01), 32'd88, 1, 8'h02};

        // Power-on reset: held low for 8 time units.
        #1 RESET = 1'b0;
        #1;
        model_reset();
        compare_state("por_during");
        #7 RESET = 1'b1;
        #1;
        compare_state("por_after");
        run(32'hFF00_0000, "nop0");
        check("nop_pc4", PC_OUT, 32'd4);
        run(32'hFF00_0000, "nop1");
        check("nop_pc8", PC_OUT, 32'd8);
        run(32'hFF00_0000, "nop2");
        check("nop_pc12", PC_OUT, 32'd12);

        // Directed ALU table from a clean reset.
        pulse_reset("tbl_rst");
        for (int i = 0; i < 22; i++) begin
            run(vecs[i].instr, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_pc", i), PC_OUT, vecs[i].exp_pc);
            check($sformatf("tbl%0d_val", i), {24'd0, dut.u_regfile.reg_array[vecs[i].reg_idx]},
                  {24'd0, vecs[i].exp_val});
        end

        // Control flow corners.
        pulse_reset("cf_rst");
        for (int i = 0; i < 4; i++) run(32'hFF00_0000, "cf_nop");
        run(enc(8'h07, 8'hFD, 3'd1, 8'h02), "beq_eq");
        check("beq_eq_pc", PC_OUT, 32'd8);
        run(enc(8'h06, 8'h02, 3'd0, 8'h00), "j_fwd");
        check("j_fwd_pc", PC_OUT, 32'd20);
        run(enc(8'h00, 8'h01, 3'd0, 8'h01), "cf_ld");
        run(enc(8'h07, 8'hFD, 3'd1, 8'h02), "beq_ne");
        check("beq_ne_pc", PC_OUT, 32'd28);
        run(enc(8'h08, 8'hFD, 3'd1, 8'h02), "bne_ne");
        check("bne_ne_pc", PC_OUT, 32'd20);
        run(enc(8'h08, 8'hFD, 3'd0, 8'h00), "bne_eq");
        check("bne_eq_pc", PC_OUT, 32'd24);
        run(enc(8'h06, 8'hFF, 3'd0, 8'h00), "j_self");
        check("j_self_pc", PC_OUT, 32'd24);

        // Asynchronous reset mid-run at PC=24, checked before the next edge.
        @(negedge CLK);
        #1 RESET = 1'b0;
        #1;
        check("arst_pc", PC_OUT, 32'd0);
        check("arst_r1", {24'd0, dut.u_regfile.reg_array[1]}, 32'd0);
        model_reset();
        compare_state("arst");
        #1 RESET = 1'b1;

        // PC wraps below zero and back.
        run(enc(8'h06, 8'hFE, 3'd0, 8'h00), "wrap_j");
        check("wrap_j_pc", PC_OUT, 32'hFFFF_FFFC);
        run(32'hFF00_0000, "wrap_nop");
        check("wrap_nop_pc", PC_OUT, 32'd0);

        // Random instructions against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            r = $urandom;
            r[31:24] = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r[7:0] = 8'($urandom_range(0, 10));
            run(r, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
